// File: rtl/complex_res_accumulator.sv
// ---------------------------------------------------------------------------
// complex_res_accumulator
//
// Consumer stage behind the complex multiplier. It takes ACC_LEN consecutive
// complex products over the res_val/res_ready handshake and adds them into a
// signed complex accumulator. The real and imaginary parts are summed
// separately. Each finished sum is offered on acc_val/acc_ready. Once it has
// been taken, the accumulator clears and the next block starts.
//
// Parameters
//   RES_WIDTH  width of each signed product part
//   ACC_LEN    products summed per output (2..255)
//   ACC_WIDTH  signed accumulator/output width; sums wrap modulo 2^ACC_WIDTH
//
// Ports
//   clk        clock, rising edge
//   rstn       asynchronous reset, active low
//   sw_rst     synchronous software reset, active high, highest priority
//   res_val    product valid from multiplier
//   res_ready  block can accept a product (registered)
//   res_re     product real part (signed)
//   res_im     product imaginary part (signed)
//   acc_val    accumulated sum valid (registered)
//   acc_ready  downstream takes the sum
//   acc_re     accumulated real part (signed, registered)
//   acc_im     accumulated imaginary part (signed, registered)
//   acc_cnt    products accepted in the current block (registered)
//   busy       a block is partially or fully accumulated (registered)
// ---------------------------------------------------------------------------
module complex_res_accumulator #(
    parameter int RES_WIDTH = 18,
    parameter int ACC_LEN   = 4,
    parameter int ACC_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 sw_rst,
    input  logic                 res_val,
    output logic                 res_ready,
    input  logic [RES_WIDTH-1:0] res_re,
    input  logic [RES_WIDTH-1:0] res_im,
    output logic                 acc_val,
    input  logic                 acc_ready,
    output logic [ACC_WIDTH-1:0] acc_re,
    output logic [ACC_WIDTH-1:0] acc_im,
    output logic [7:0]           acc_cnt,
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [7:0] ACC_LEN_C = 8'(ACC_LEN);

    // The sized cast of a signed value sign-extends to the accumulator width.
    // It also works when ACC_WIDTH equals RES_WIDTH, where an explicit
    // replication count would be zero.
    function automatic logic [ACC_WIDTH-1:0] sext(input logic [RES_WIDTH-1:0] v);
        sext = ACC_WIDTH'($signed(v));
    endfunction

    state_t                 state_r;
    logic                   res_ready_r;
    logic                   acc_val_r;
    logic [ACC_WIDTH-1:0]   acc_re_r;
    logic [ACC_WIDTH-1:0]   acc_im_r;
    logic [7:0]             acc_cnt_r;
    logic                   busy_r;

    logic                   beat_s;
    logic                   last_beat_s;
    logic [7:0]             cnt_inc_s;
    logic [ACC_WIDTH-1:0]   sum_re_s;
    logic [ACC_WIDTH-1:0]   sum_im_s;

    // Next-sum datapath and beat qualification
    always_comb begin
        beat_s      = res_val & res_ready_r;
        cnt_inc_s   = acc_cnt_r + 8'd1;
        last_beat_s = (cnt_inc_s == ACC_LEN_C);
        sum_re_s    = acc_re_r + sext(res_re);
        sum_im_s    = acc_im_r + sext(res_im);
    end

    // Control FSM and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            res_ready_r <= 1'b0;
            acc_val_r   <= 1'b0;
            acc_re_r    <= '0;
            acc_im_r    <= '0;
            acc_cnt_r   <= 8'd0;
            busy_r      <= 1'b0;
        end else if (sw_rst) begin
            // Discards any partial or pending sum
            state_r     <= ST_IDLE;
            res_ready_r <= 1'b0;
            acc_val_r   <= 1'b0;
            acc_re_r    <= '0;
            acc_im_r    <= '0;
            acc_cnt_r   <= 8'd0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r     <= ST_ACCUM;
                    res_ready_r <= 1'b1;
                end
                ST_ACCUM: begin
                    if (beat_s) begin
                        acc_re_r  <= sum_re_s;
                        acc_im_r  <= sum_im_s;
                        acc_cnt_r <= cnt_inc_s;
                        busy_r    <= 1'b1;
                        if (last_beat_s) begin
                            state_r     <= ST_DONE;
                            res_ready_r <= 1'b0;
                            acc_val_r   <= 1'b1;
                        end else begin
                            state_r <= ST_ACCUM;
                        end
                    end else begin
                        state_r <= ST_ACCUM;
                    end
                end
                ST_DONE: begin
                    // acc_val is always 1 here, so acc_ready alone completes
                    // the handoff.
                    if (acc_ready) begin
                        state_r     <= ST_ACCUM;
                        res_ready_r <= 1'b1;
                        acc_val_r   <= 1'b0;
                        acc_re_r    <= '0;
                        acc_im_r    <= '0;
                        acc_cnt_r   <= 8'd0;
                        busy_r      <= 1'b0;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to the reset state
                    state_r     <= ST_IDLE;
                    res_ready_r <= 1'b0;
                    acc_val_r   <= 1'b0;
                    acc_re_r    <= '0;
                    acc_im_r    <= '0;
                    acc_cnt_r   <= 8'd0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign res_ready = res_ready_r;
    assign acc_val   = acc_val_r;
    assign acc_re    = acc_re_r;
    assign acc_im    = acc_im_r;
    assign acc_cnt   = acc_cnt_r;
    assign busy      = busy_r;

endmodule
